m_col_tdc: RTL and testbench

M_COL_TDC -- requirements
Module: m_col_tdc

---
 rtl/m_col_tdc.sv | 164 ++++++++++++++++
 tb/tb_m_col_tdc.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/m_col_tdc.sv
// rtl/m_col_tdc.sv - two-channel column sense-amp time-to-digital converter
module m_col_tdc #(
  parameter int CNT_W       = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pre_charge_ctrl,
  input  logic             read1_ctrl,
  input  logic             read2_ctrl,
  input  logic             sa_out1,
  input  logic             sa_out2,
  input  logic             res_ready,
  output logic             res_valid,
  output logic [CNT_W-1:0] code1,
  output logic [CNT_W-1:0] code2,
  output logic [CNT_W:0]   diff,
  output logic             tout1,
  output logic             tout2,
  output logic             overrun,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ARMED, MEASURE, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] pc_sync, rd1_sync, rd2_sync, sa1_sync, sa2_sync, vld_sync;
  logic                   pc_low, rd, sa1_s, sa2_s, sa1_q, sa2_q, sa1_rise, sa2_rise;
  logic [CNT_W-1:0]       cnt, cnt_inc, code1_int, code2_int, fin1, fin2;
  logic                   stop1, stop2, fin_to1, fin_to2;
  logic                   start, finish, accept, ovr_set;

  // Synchronize every asynchronous input; vld_sync marks when the chains hold real samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_sync  <= '0;
      rd1_sync <= '0;
      rd2_sync <= '0;
      sa1_sync <= '0;
      sa2_sync <= '0;
      vld_sync <= '0;
    end else begin
      pc_sync[0]  <= pre_charge_ctrl;
      rd1_sync[0] <= read1_ctrl;
      rd2_sync[0] <= read2_ctrl;
      sa1_sync[0] <= sa_out1;
      sa2_sync[0] <= sa_out2;
      vld_sync[0] <= 1'b1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        pc_sync[i]  <= pc_sync[i-1];
        rd1_sync[i] <= rd1_sync[i-1];
        rd2_sync[i] <= rd2_sync[i-1];
        sa1_sync[i] <= sa1_sync[i-1];
        sa2_sync[i] <= sa2_sync[i-1];
        vld_sync[i] <= vld_sync[i-1];
      end
    end
  end

  // The cleared chain reads as precharge-low after reset, so only trust it once refilled
  assign pc_low   = vld_sync[SYNC_STAGES-1] & ~pc_sync[SYNC_STAGES-1];
  assign rd       = rd1_sync[SYNC_STAGES-1] & rd2_sync[SYNC_STAGES-1];
  assign sa1_s    = sa1_sync[SYNC_STAGES-1];
  assign sa2_s    = sa2_sync[SYNC_STAGES-1];
  assign sa1_rise = sa1_s & ~sa1_q;
  assign sa2_rise = sa2_s & ~sa2_q;

  // Count including the current cycle, so an edge k cycles after the window opens reads k
  assign cnt_inc = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);

  // Final codes at window close; an edge in the closing cycle still stops the channel
  assign fin1    = stop1 ? code1_int : (sa1_rise ? cnt_inc : CNT_MAX);
  assign fin2    = stop2 ? code2_int : (sa2_rise ? cnt_inc : CNT_MAX);
  assign fin_to1 = (!stop1 && !sa1_rise) || (fin1 == CNT_MAX);
  assign fin_to2 = (!stop2 && !sa2_rise) || (fin2 == CNT_MAX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and single-cycle datapath strobes
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    finish  = 1'b0;
    accept  = 1'b0;
    ovr_set = 1'b0;
    case (state_q)
      IDLE:    if (pc_low) state_d = ARMED;
      ARMED:   if (rd) begin
                 state_d = MEASURE;
                 start   = 1'b1;
               end
      MEASURE: if (!rd) begin
                 state_d = HOLD;
                 finish  = 1'b1;
               end
      HOLD: begin
        if (pc_low) ovr_set = 1'b1;
        if (res_valid && res_ready) begin
          state_d = IDLE;
          accept  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter, per-channel stop capture and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa1_q     <= 1'b0;
      sa2_q     <= 1'b0;
      cnt       <= '0;
      stop1     <= 1'b0;
      stop2     <= 1'b0;
      code1_int <= '0;
      code2_int <= '0;
      code1     <= '0;
      code2     <= '0;
      diff      <= '0;
      tout1     <= 1'b0;
      tout2     <= 1'b0;
      res_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sa1_q <= sa1_s;
      sa2_q <= sa2_s;
      if (start) begin
        cnt   <= '0;
        stop1 <= 1'b0;
        stop2 <= 1'b0;
      end else if (state_q == MEASURE) begin
        cnt <= cnt_inc;
        if (sa1_rise && !stop1) begin
          stop1     <= 1'b1;
          code1_int <= cnt_inc;
        end
        if (sa2_rise && !stop2) begin
          stop2     <= 1'b1;
          code2_int <= cnt_inc;
        end
      end
      if (finish) begin
        code1     <= fin1;
        code2     <= fin2;
        diff      <= {1'b0, fin1} - {1'b0, fin2};
        tout1     <= fin_to1;
        tout2     <= fin_to2;
        res_valid <= 1'b1;
      end
      if (accept)  res_valid <= 1'b0;
      if (ovr_set) overrun   <= 1'b1;
    end
  end

  assign busy = (state_q == ARMED) || (state_q == MEASURE);

endmodule

// File: tb/tb_m_col_tdc.sv
// tb/tb_m_col_tdc.sv - randomized self-checking bench for m_col_tdc
module tb_m_col_tdc;

  logic clk = 1'b0;
  logic rst_n, pc, rd1, rd2, sa1, sa2, rdy;

  logic        a_valid, a_t1, a_t2, a_ovr, a_busy;
  logic [9:0]  a_c1, a_c2;
  logic [10:0] a_diff;
  logic        b_valid, b_t1, b_t2, b_ovr, b_busy;
  logic [3:0]  b_c1, b_c2;
  logic [4:0]  b_diff;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: a window is a set of results, HOLD is "results not yet taken"
  bit hold = 0;
  bit ovr  = 0;
  int e_c1[2], e_c2[2], e_t1[2], e_t2[2];
  int mx[2] = '{1023, 15};

  m_col_tdc #(.CNT_W(10), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .pre_charge_ctrl(pc), .read1_ctrl(rd1), .read2_ctrl(rd2),
    .sa_out1(sa1), .sa_out2(sa2), .res_ready(rdy), .res_valid(a_valid), .code1(a_c1),
    .code2(a_c2), .diff(a_diff), .tout1(a_t1), .tout2(a_t2), .overrun(a_ovr), .busy(a_busy)
  );

  m_col_tdc #(.CNT_W(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .pre_charge_ctrl(pc), .read1_ctrl(rd1), .read2_ctrl(rd2),
    .sa_out1(sa1), .sa_out2(sa2), .res_ready(rdy), .res_valid(b_valid), .code1(b_c1),
    .code2(b_c2), .diff(b_diff), .tout1(b_t1), .tout2(b_t2), .overrun(b_ovr), .busy(b_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit stopped(input int k, input int len);
    return (k >= 1) && (k <= len);
  endfunction

  function automatic int ecode(input int k, input int len, input int m);
    if (!stopped(k, len)) return m;
    return (k < m) ? k : m;
  endfunction

  function automatic int etout(input int k, input int len, input int m);
    return (!stopped(k, len) || k >= m) ? 1 : 0;
  endfunction

  task automatic check_all(input string tag);
    check({tag, " a.valid"}, int'(a_valid), int'(hold));
    check({tag, " a.code1"}, int'(a_c1), e_c1[0]);
    check({tag, " a.code2"}, int'(a_c2), e_c2[0]);
    check({tag, " a.diff"}, int'($signed(a_diff)), e_c1[0] - e_c2[0]);
    check({tag, " a.tout1"}, int'(a_t1), e_t1[0]);
    check({tag, " a.tout2"}, int'(a_t2), e_t2[0]);
    check({tag, " a.overrun"}, int'(a_ovr), int'(ovr));
    check({tag, " b.valid"}, int'(b_valid), int'(hold));
    check({tag, " b.code1"}, int'(b_c1), e_c1[1]);
    check({tag, " b.code2"}, int'(b_c2), e_c2[1]);
    check({tag, " b.diff"}, int'($signed(b_diff)), e_c1[1] - e_c2[1]);
    check({tag, " b.tout1"}, int'(b_t1), e_t1[1]);
    check({tag, " b.tout2"}, int'(b_t2), e_t2[1]);
    check({tag, " b.overrun"}, int'(b_ovr), int'(ovr));
  endtask

  task automatic check_busy(input string tag, input int exp);
    check({tag, " a.busy"}, int'(a_busy), exp);
    check({tag, " b.busy"}, int'(b_busy), exp);
  endtask

  task automatic clear_model();
    hold = 0;
    ovr  = 0;
    for (int w = 0; w < 2; w++) begin
      e_c1[w] = 0; e_c2[w] = 0; e_t1[w] = 0; e_t2[w] = 0;
    end
  endtask

  // One precharge + read window; k = rise cycle relative to window open (-1 never),
  // g1 = second sa_out1 rise after a 3-cycle pulse (-1 none)
  task automatic window(input string tag, input int k1, input int g1, input int k2,
                        input int len, input bit take);
    @(negedge clk); sa1 = 0; sa2 = 0; pc = 0;
    @(negedge clk); pc = 1;
    repeat (4) @(negedge clk);
    check_busy({tag, " armed"}, hold ? 0 : 1);
    for (int c = 0; c <= len + 10; c++) begin
      rd1 = (c < len);
      rd2 = (c < len);
      if (c == k1) sa1 = 1;
      if (g1 >= 0 && c == k1 + 3) sa1 = 0;
      if (c == g1) sa1 = 1;
      if (c == k2) sa2 = 1;
      @(negedge clk);
    end
    if (!hold) begin
      for (int w = 0; w < 2; w++) begin
        e_c1[w] = ecode(k1, len, mx[w]);
        e_c2[w] = ecode(k2, len, mx[w]);
        e_t1[w] = etout(k1, len, mx[w]);
        e_t2[w] = etout(k2, len, mx[w]);
      end
      hold = 1;
    end else begin
      ovr = 1;
    end
    check_all({tag, " result"});
    check_busy({tag, " hold"}, 0);
    repeat (5) @(negedge clk);
    check({tag, " a.valid_held"}, int'(a_valid), 1);
    sa1 = 0; sa2 = 0;
    if (take) begin
      rdy = 1;
      @(negedge clk);
      rdy = 0;
      hold = 0;
      check_all({tag, " taken"});
    end
  endtask

  initial begin
    int len, k1, k2;
    rst_n = 0; pc = 1; rd1 = 0; rd2 = 0; sa1 = 0; sa2 = 0; rdy = 0;
    clear_model();
    repeat (3) @(negedge clk);
    check_all("reset");
    check_busy("reset", 0);
    rst_n = 1;
    repeat (5) @(negedge clk);
    check_busy("idle_after_reset", 0);

    window("basic", 40, -1, 90, 150, 1);
    window("no_sa2", 40, -1, -1, 150, 1);
    window("sat", 20, -1, 25, 30, 1);
    window("glitch", 10, 30, 55, 80, 1);
    window("edge_at_close", 60, -1, 1, 60, 1);
    window("sat_edge", 15, -1, 14, 40, 1);
    window("after_close", 70, -1, 12, 50, 1);

    window("ovr_a", 33, -1, 44, 60, 0);
    window("ovr_b", 5, -1, 6, 60, 0);
    rdy = 1; @(negedge clk); rdy = 0; hold = 0;
    check_all("ovr_taken");
    window("ovr_next", 21, -1, 17, 60, 1);

    for (int i = 0; i < 12; i++) begin
      len = $urandom_range(20, 120);
      k1 = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(1, len + 5));
      k2 = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(1, len + 5));
      window($sformatf("rnd%0d", i), k1, -1, k2, len, $urandom_range(0, 3) != 0);
    end
    if (hold) begin
      rdy = 1; @(negedge clk); rdy = 0; hold = 0;
    end

    // reset in the middle of a measurement
    window("pre_rst", 12, -1, 30, 40, 1);
    @(negedge clk); pc = 0;
    @(negedge clk); pc = 1;
    repeat (4) @(negedge clk);
    for (int c = 0; c < 60; c++) begin
      rd1 = 1; rd2 = 1;
      if (c == 20) sa1 = 1;
      @(negedge clk);
    end
    check_busy("mid_measure", 1);
    #2 rst_n = 0;
    #1;
    clear_model();
    check_all("async_reset");
    check_busy("async_reset", 0);
    @(negedge clk); rst_n = 1;
    repeat (10) @(negedge clk);
    check_busy("rd_no_precharge", 0);
    rd1 = 0; rd2 = 0; sa1 = 0;
    repeat (5) @(negedge clk);
    check_busy("still_idle", 0);
    check_all("still_idle");
    window("post_rst", 33, -1, 77, 100, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
